// File: rtl/psram_xfer_ctrl.sv
// QSPI PSRAM single-word transfer engine: 0x38 quad write / 0xEB quad read of one 32-bit word.
// Define PSRAM_XFER_CNT_EN to add xfer_cnt_o, a wrapping count of completed transfers.
module psram_xfer_ctrl #(
  parameter int ADDR_WIDTH = 24,
  parameter int DUMMY_DEF  = 6
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [7:0]            div_i,
  input  logic [3:0]            dummy_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [31:0]           req_wdata_i,
  output logic                  rsp_valid_o,
  output logic [31:0]           rsp_rdata_o,
  output logic                  psram_sck_o,
  output logic                  psram_ce_o,
  output logic [3:0]            psram_io_en_o,
  output logic [3:0]            psram_io_out_o,
  input  logic [3:0]            psram_io_in_i
`ifdef PSRAM_XFER_CNT_EN
  ,
  output logic [31:0]           xfer_cnt_o
`endif
);

  localparam int TXW       = 8 + ADDR_WIDTH + 32;
  localparam int ADDR_NIBS = ADDR_WIDTH / 4;

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, CPH} state_t;

  state_t           state;
  logic             we;
  logic [7:0]       h_eff;
  logic [7:0]       n_dummy;
  logic [8:0]       div_cnt;
  logic [7:0]       nib_cnt;
  logic [TXW-1:0]   tx_sr;
  logic [31:0]      rx_sr;

  logic [7:0]       div_sel;
  logic [7:0]       dummy_sel;
  logic [7:0]       cmd;
  logic [TXW-1:0]   frame;
  logic             phase_end;
  logic             cph_end;
  logic             last_nib;

  // The whole outgoing nibble stream is pre-built at acceptance; data bytes go LSB byte first.
  always_comb begin
    div_sel   = (div_i == 8'd0) ? 8'd1 : div_i;
    dummy_sel = (dummy_i == 4'd0) ? 8'(DUMMY_DEF) : {4'd0, dummy_i};
    cmd       = req_we_i ? 8'h38 : 8'hEB;
    frame     = {cmd, req_addr_i, req_wdata_i[7:0], req_wdata_i[15:8],
                 req_wdata_i[23:16], req_wdata_i[31:24]};
    phase_end = (div_cnt == ({1'b0, h_eff} - 9'd1));
    cph_end   = (div_cnt == ({h_eff, 1'b0} - 9'd1));
    last_nib  = (nib_cnt == 8'd0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= IDLE;
      we             <= 1'b0;
      h_eff          <= 8'd1;
      n_dummy        <= 8'd0;
      div_cnt        <= 9'd0;
      nib_cnt        <= 8'd0;
      tx_sr          <= '0;
      rx_sr          <= 32'd0;
      req_ready_o    <= 1'b1;
      rsp_valid_o    <= 1'b0;
      rsp_rdata_o    <= 32'd0;
      psram_sck_o    <= 1'b0;
      psram_ce_o     <= 1'b1;
      psram_io_en_o  <= 4'h0;
      psram_io_out_o <= 4'h0;
    end else begin
      rsp_valid_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid_i) begin
            state          <= CMD;
            req_ready_o    <= 1'b0;
            we             <= req_we_i;
            h_eff          <= div_sel;
            n_dummy        <= dummy_sel;
            div_cnt        <= 9'd0;
            nib_cnt        <= 8'd1;
            psram_ce_o     <= 1'b0;
            psram_sck_o    <= 1'b0;
            psram_io_en_o  <= 4'hF;
            psram_io_out_o <= frame[TXW-1 -: 4];
            tx_sr          <= frame << 4;
          end
        end
        CMD, ADDR, DUMMY, DATA: begin
          if (!phase_end) begin
            div_cnt <= div_cnt + 9'd1;
          end else begin
            div_cnt <= 9'd0;
            if (!psram_sck_o) begin
              psram_sck_o <= 1'b1;
              if (state == DATA && !we)
                rx_sr <= {rx_sr[27:0], psram_io_in_i};
            end else begin
              // Falling edge: the only point where the outgoing nibble and the phase advance.
              psram_sck_o    <= 1'b0;
              nib_cnt        <= nib_cnt - 8'd1;
              psram_io_out_o <= tx_sr[TXW-1 -: 4];
              tx_sr          <= tx_sr << 4;
              if (state == DUMMY || (state == DATA && !we))
                psram_io_out_o <= 4'h0;
              if (last_nib) begin
                case (state)
                  CMD: begin
                    state   <= ADDR;
                    nib_cnt <= 8'(ADDR_NIBS - 1);
                  end
                  ADDR: begin
                    if (we) begin
                      state   <= DATA;
                      nib_cnt <= 8'd7;
                    end else begin
                      state          <= DUMMY;
                      nib_cnt        <= n_dummy - 8'd1;
                      psram_io_en_o  <= 4'h0;
                      psram_io_out_o <= 4'h0;
                    end
                  end
                  DUMMY: begin
                    state   <= DATA;
                    nib_cnt <= 8'd7;
                  end
                  default: begin
                    state          <= CPH;
                    psram_ce_o     <= 1'b1;
                    psram_io_en_o  <= 4'h0;
                    psram_io_out_o <= 4'h0;
                    rsp_valid_o    <= 1'b1;
                    if (!we)
                      rsp_rdata_o <= {rx_sr[7:0], rx_sr[15:8], rx_sr[23:16], rx_sr[31:24]};
                  end
                endcase
              end
            end
          end
        end
        CPH: begin
          if (cph_end) begin
            state       <= IDLE;
            req_ready_o <= 1'b1;
            div_cnt     <= 9'd0;
          end else begin
            div_cnt <= div_cnt + 9'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PSRAM_XFER_CNT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i)
      xfer_cnt_o <= 32'd0;
    else if (rsp_valid_o)
      xfer_cnt_o <= xfer_cnt_o + 32'd1;
  end
`endif

endmodule

// File: tb/tb_psram_xfer_ctrl.sv
// Scoreboard bench for psram_xfer_ctrl: stimulus queues expected nibbles/responses, a monitor checks them.
// Builds with or without PSRAM_XFER_CNT_EN; counter checks only exist when the macro is defined.
module tb_psram_xfer_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [7:0]  div_i = 8'd1;
  logic [3:0]  dummy_i = 4'd0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_we_i = 1'b0;
  logic [23:0] req_addr_i = 24'd0;
  logic [31:0] req_wdata_i = 32'd0;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        psram_sck_o;
  logic        psram_ce_o;
  logic [3:0]  psram_io_en_o;
  logic [3:0]  psram_io_out_o;
  logic [3:0]  psram_io_in_i = 4'h0;
`ifdef PSRAM_XFER_CNT_EN
  logic [31:0] xfer_cnt_o;
`endif

  always #5 clk_i = ~clk_i;

  psram_xfer_ctrl #(.ADDR_WIDTH(24), .DUMMY_DEF(6)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .div_i          (div_i),
    .dummy_i        (dummy_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_we_i       (req_we_i),
    .req_addr_i     (req_addr_i),
    .req_wdata_i    (req_wdata_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_rdata_o    (rsp_rdata_o),
    .psram_sck_o    (psram_sck_o),
    .psram_ce_o     (psram_ce_o),
    .psram_io_en_o  (psram_io_en_o),
    .psram_io_out_o (psram_io_out_o),
    .psram_io_in_i  (psram_io_in_i)
`ifdef PSRAM_XFER_CNT_EN
    ,
    .xfer_cnt_o     (xfer_cnt_o)
`endif
  );

  typedef struct {
    logic        we;
    int          h;
    int          n;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  logic [3:0]  nib_q[$];
  logic [3:0]  rd_q[$];
  logic [31:0] last_rdata = 32'd0;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp)
      n_pass++;
    else
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Monitor and PSRAM read-data model; everything is sampled mid-cycle on the falling clock.
  int         rise_cnt = 0;
  int         ce_low = 0;
  int         since_rise = 0;
  int         cph_cnt = 0;
  int         cph_h = 1;
  bit         in_cph = 1'b0;
  logic       sck_prev = 1'b0;
  logic       ce_prev = 1'b1;
  logic [3:0] io_prev = 4'h0;
  exp_t       cur;
  logic [3:0] exp_en;

  always @(negedge clk_i) begin
    if (rst_i) begin
      rise_cnt      = 0;
      ce_low        = 0;
      since_rise    = 0;
      in_cph        = 1'b0;
      cph_cnt       = 0;
      psram_io_in_i = 4'h0;
    end else begin
      since_rise++;
      if (!psram_ce_o) begin
        ce_low++;
        checkOutput("ready_low_while_busy", {31'd0, req_ready_o}, 32'd0);
      end
      if (psram_io_out_o !== io_prev)
        checkOutput("io_out_changes_on_fall", {31'd0, (sck_prev && !psram_sck_o) || (ce_prev && !psram_ce_o)}, 32'd1);
      if (psram_sck_o && !sck_prev) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_sck_rise", 32'd1, 32'd0);
        end else begin
          cur = exp_q[0];
          if (rise_cnt == 0)
            checkOutput("first_rise_delay", ce_low, cur.h + 1);
          else
            checkOutput("sck_period", since_rise, 2 * cur.h);
          since_rise = 0;
          rise_cnt++;
          exp_en = (cur.we || rise_cnt <= 8) ? 4'hF : 4'h0;
          checkOutput("io_en", {28'd0, psram_io_en_o}, {28'd0, exp_en});
          if (exp_en == 4'hF) begin
            if (nib_q.size() == 0)
              checkOutput("nibble_underflow", 32'd1, 32'd0);
            else
              checkOutput("nibble", {28'd0, psram_io_out_o}, {28'd0, nib_q.pop_front()});
          end else if (rise_cnt >= 8 + cur.n && rd_q.size() > 0) begin
            psram_io_in_i = rd_q.pop_front();
          end
        end
      end
      if (rsp_valid_o) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_rsp_valid", 32'd1, 32'd0);
        end else begin
          cur = exp_q.pop_front();
          checkOutput("sck_rise_count", rise_cnt, cur.we ? 16 : 16 + cur.n);
          checkOutput("ce_low_cycles", ce_low, (cur.we ? 16 : 16 + cur.n) * 2 * cur.h);
          checkOutput("rsp_rdata", rsp_rdata_o, cur.rdata);
          checkOutput("cph_entry_pins", {26'd0, psram_ce_o, psram_sck_o, psram_io_en_o}, {26'd0, 1'b1, 1'b0, 4'h0});
          in_cph   = 1'b1;
          cph_cnt  = 1;
          cph_h    = cur.h;
          rise_cnt = 0;
          ce_low   = 0;
        end
      end else if (in_cph) begin
        if (req_ready_o) begin
          checkOutput("cph_ce_high_cycles", cph_cnt, 2 * cph_h);
          in_cph = 1'b0;
        end else begin
          cph_cnt++;
        end
      end
    end
    sck_prev = psram_sck_o;
    ce_prev  = psram_ce_o;
    io_prev  = psram_io_out_o;
  end

  // Queue the expected response/nibbles, then present the request until it is accepted.
  task automatic applyStimulus(input logic we, input logic [23:0] addr, input logic [31:0] wdata,
                               input logic [7:0] div, input logic [3:0] dummy,
                               input logic [63:0] nibs, input logic [31:0] rnibs,
                               input logic [31:0] rdata_exp, input logic hold, output int waited);
    exp_t e;
    int   cnt;
    e.we    = we;
    e.h     = (div == 8'd0) ? 1 : int'(div);
    e.n     = (dummy == 4'd0) ? 6 : int'(dummy);
    e.rdata = we ? last_rdata : rdata_exp;
    if (!we)
      last_rdata = rdata_exp;
    cnt = we ? 16 : 8;
    for (int i = 0; i < cnt; i++)
      nib_q.push_back(nibs[63-4*i -: 4]);
    if (!we)
      for (int i = 0; i < 8; i++)
        rd_q.push_back(rnibs[31-4*i -: 4]);
    exp_q.push_back(e);
    req_valid_i = 1'b1;
    req_we_i    = we;
    req_addr_i  = addr;
    req_wdata_i = wdata;
    div_i       = div;
    dummy_i     = dummy;
    waited = 0;
    while (!req_ready_o && waited < 2000) begin
      @(negedge clk_i);
      waited++;
    end
    if (!req_ready_o)
      checkOutput("accept_timeout", 32'd0, 32'd1);
    @(negedge clk_i);
    if (!hold)
      req_valid_i = 1'b0;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !req_ready_o || in_cph) && n < 3000) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 3000)
      checkOutput("idle_timeout", 32'd0, 32'd1);
    repeat (2) @(negedge clk_i);
  endtask

  task automatic checkResetPins(input string name);
    checkOutput(name, {24'd0, psram_ce_o, psram_sck_o, psram_io_en_o, rsp_valid_o, 1'b0},
                {24'd0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0});
    checkOutput({name, "_io_out"}, {28'd0, psram_io_out_o}, 32'd0);
    checkOutput({name, "_rdata"}, rsp_rdata_o, 32'd0);
  endtask

  initial begin
    int w;
    int w2;
    int n;
    repeat (3) @(negedge clk_i);
    checkResetPins("reset_state");
    checkOutput("reset_ready", {31'd0, req_ready_o}, 32'd1);
    #1 rst_i = 1'b0;
    @(negedge clk_i);

    $display("[TB] write div=1");
    applyStimulus(1'b1, 24'h000100, 32'hA1B2C3D4, 8'd1, 4'd0, 64'h38000100D4C3B2A1, 32'd0, 32'd0, 1'b0, w);
    waitIdle();

    $display("[TB] read dummy=0 (default 6)");
    applyStimulus(1'b0, 24'h000100, 32'd0, 8'd1, 4'd0, 64'hEB00010000000000, 32'hD4C3B2A1, 32'hA1B2C3D4, 1'b0, w);
    waitIdle();

    $display("[TB] write div=0 behaves as div=1");
    applyStimulus(1'b1, 24'h123456, 32'h89ABCDEF, 8'd0, 4'd0, 64'h38123456EFCDAB89, 32'd0, 32'd0, 1'b0, w);
    waitIdle();

    $display("[TB] write div=3");
    applyStimulus(1'b1, 24'hABCDEF, 32'h01234567, 8'd3, 4'd0, 64'h38ABCDEF67452301, 32'd0, 32'd0, 1'b0, w);
    waitIdle();

    $display("[TB] read div=2 dummy=3, div/dummy changed mid-transfer");
    applyStimulus(1'b0, 24'h00FF00, 32'd0, 8'd2, 4'd3, 64'hEB00FF0000000000, 32'h5AF01234, 32'h3412F05A, 1'b0, w);
    div_i   = 8'd7;
    dummy_i = 4'd9;
    waitIdle();

    $display("[TB] back-to-back with valid held high");
    applyStimulus(1'b1, 24'h000004, 32'h11223344, 8'd1, 4'd0, 64'h3800000444332211, 32'd0, 32'd0, 1'b1, w);
    applyStimulus(1'b0, 24'h000008, 32'd0, 8'd1, 4'd2, 64'hEB00000800000000, 32'h87654321, 32'h21436587, 1'b0, w2);
    checkOutput("b2b_first_wait", w, 32'd0);
    checkOutput("b2b_second_wait", w2, 32'd34);
    waitIdle();

    $display("[TB] reset at 5th sck of a read");
    applyStimulus(1'b0, 24'h000010, 32'd0, 8'd1, 4'd0, 64'hEB00001000000000, 32'h12345678, 32'h78563412, 1'b0, w);
    n = 0;
    while (rise_cnt < 5 && n < 500) begin
      @(negedge clk_i);
      #1;
      n++;
    end
    checkOutput("reached_5th_sck", rise_cnt, 32'd5);
    rst_i = 1'b1;
    exp_q.delete();
    nib_q.delete();
    rd_q.delete();
    last_rdata = 32'd0;
    @(negedge clk_i);
    checkResetPins("midxfer_reset");
    @(negedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    checkOutput("ready_after_reset", {31'd0, req_ready_o}, 32'd1);
    repeat (40) @(negedge clk_i);

    $display("[TB] writes after reset");
    applyStimulus(1'b1, 24'h000020, 32'hDEADBEEF, 8'd1, 4'd0, 64'h38000020EFBEADDE, 32'd0, 32'd0, 1'b0, w);
    waitIdle();
    applyStimulus(1'b1, 24'h000024, 32'h0000FFFF, 8'd2, 4'd0, 64'h38000024FFFF0000, 32'd0, 32'd0, 1'b0, w);
    waitIdle();
    applyStimulus(1'b1, 24'hFFFFFC, 32'h76543210, 8'd1, 4'd0, 64'h38FFFFFC10325476, 32'd0, 32'd0, 1'b0, w);
    waitIdle();

`ifdef PSRAM_XFER_CNT_EN
    checkOutput("xfer_cnt_three", xfer_cnt_o, 32'd3);
    force dut.xfer_cnt_o = 32'hFFFFFFFF;
    @(negedge clk_i);
    release dut.xfer_cnt_o;
    applyStimulus(1'b1, 24'h000000, 32'h00000001, 8'd1, 4'd0, 64'h3800000001000000, 32'd0, 32'd0, 1'b0, w);
    waitIdle();
    checkOutput("xfer_cnt_wrap", xfer_cnt_o, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/psram_xfer_ctrl.md
PSRAM_XFER_CTRL -- requirements
Module: psram_xfer_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 24, byte address width sent to the device.
REQ-002 SHALL have parameter DUMMY_DEF, default 6, the dummy SCK count used when dummy_i is 0.
REQ-003 SHALL have port clk_i, input, 1, the single clock for all logic.
REQ-004 SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-005 SHALL have port div_i, input, 8, SCK half-period in clk_i cycles; 0 SHALL be treated as 1.
REQ-006 SHALL have port dummy_i, input, 4, read wait SCK cycles; 0 SHALL select DUMMY_DEF.
REQ-007 SHALL have ports req_valid_i (input, 1) and req_ready_o (output, 1), the request handshake.
REQ-008 SHALL have port req_we_i, input, 1, where 1 = write (cmd 0x38) and 0 = read (cmd 0xEB).
REQ-009 SHALL have ports req_addr_i (input, ADDR_WIDTH) and req_wdata_i (input, 32), the address and write data.
REQ-010 SHALL have ports rsp_valid_o (output, 1) and rsp_rdata_o (output, 32): a one-cycle completion pulse, plus read data.
REQ-011 SHALL have ports psram_sck_o (output, 1), psram_ce_o (output, 1, active low), psram_io_en_o (output, 4), psram_io_out_o (output, 4) and psram_io_in_i (input, 4).

Function
REQ-012 SHALL implement the FSM IDLE -> CMD(2 nibbles) -> ADDR(ADDR_WIDTH/4 nibbles) -> [read: DUMMY(N SCK)] -> DATA(8 nibbles) -> CPH -> IDLE.
REQ-013 SHALL assert req_ready_o only in IDLE; on valid&&ready it SHALL latch we, addr and wdata, and a request arriving while busy SHALL be held off.
REQ-014 SHALL drive psram_ce_o low from the cycle after acceptance until CPH entry; the first nibble SHALL be valid on that same cycle with SCK low.
REQ-015 SHALL make each SCK phase last the effective div (H) clk cycles, low then high; io_out SHALL change only on the clk edge where SCK falls (or at CE fall).
REQ-016 SHALL send all nibbles MSB-first; data bytes SHALL go in the order wdata[7:0], [15:8], [23:16], [31:24], high nibble first.
REQ-017 SHALL hold psram_io_en_o at 4'hF during CMD, ADDR and write DATA, and at 4'h0 during DUMMY, read DATA, CPH and IDLE.
REQ-018 SHALL sample psram_io_in_i into a register on the clk edge where SCK rises during read DATA, and assemble the samples with the same byte/nibble order as REQ-016.
REQ-019 SHALL return psram_sck_o low after the last DATA rising phase, then raise CE in CPH and hold it high for 2*H clk cycles before IDLE.
REQ-020 SHALL pulse rsp_valid_o for one cycle on CPH entry for both reads and writes; rsp_rdata_o SHALL hold its value until the next read completes (writes leave it unchanged).
REQ-021 SHALL sample div_i and dummy_i at acceptance; changes during a transfer SHALL have no effect.
REQ-022 SHALL produce exactly 16 SCK rising edges for a write and 16+N for a read.

Reset
REQ-023 SHALL on rst_i=1, at any clock edge including mid-transfer, reach next cycle: IDLE, psram_ce_o=1, psram_sck_o=0, psram_io_en_o=0, psram_io_out_o=0, req_ready_o=1 (after release), rsp_valid_o=0, rsp_rdata_o=0.
REQ-024 SHALL NOT emit rsp_valid_o for an aborted transfer.

Configuration
REQ-025 SHALL provide macro PSRAM_XFER_CNT_EN; when defined it SHALL add output xfer_cnt_o[31:0], counting rsp_valid_o pulses, reset to 0 and wrapping 0xFFFFFFFF->0.
REQ-026 SHALL omit the port and counter entirely when PSRAM_XFER_CNT_EN is undefined, with all other behaviour identical.

Verification
REQ-027 SHALL cover: write addr=0x000100, wdata=0x A1B2C3D4, div=1 -> nibbles 3,8,0,0,0,1,0,0,D,4,C,3,B,2,A,1, 16 SCK edges, io_en=F, rsp pulse, CE low for 32 cycles.
REQ-028 SHALL cover: read addr=0x000100, dummy=0, model returning nibbles D,4,C,3,B,2,A,1 -> 6 dummy SCKs with io_en=0, and rsp_rdata_o=0xA1B2C3D4.
REQ-029 SHALL cover: div=0 vs div=1 give identical timing, and div=3 gives an SCK period of 6 clk cycles with CE high for 6 cycles in CPH.
REQ-030 SHALL cover: req_valid_i held high with back-to-back requests -> second accepted only after CPH; req_ready_o=0 throughout the first transfer.
REQ-031 SHALL cover: rst_i asserted at the 5th SCK of a read -> next cycle CE=1, SCK=0, io_en=0, no rsp_valid_o, and a following write completes normally.
REQ-032 SHALL cover: with PSRAM_XFER_CNT_EN, 3 transfers -> xfer_cnt_o=3, and a counter preloaded to 0xFFFFFFFF via force wraps to 0.
